// File: rtl/fifo_pop_ctrl.sv
// fifo_pop_ctrl: pops the transaction-layer FIFO into a 2-entry skid buffer.
// Optional POP_STATS_EN adds pop_count / stall_count outputs.
module fifo_pop_ctrl #(
    parameter int DATA_W     = 10,
    parameter int SKID_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic              fifo_empty,
    input  logic              fifo_almost_empty,
    input  logic [DATA_W-1:0] fifo_data_out,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              flush_done,
`ifdef POP_STATS_EN
    output logic [15:0]       pop_count,
    output logic [15:0]       stall_count,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    localparam logic [2:0] SKID_LIM = 3'(SKID_DEPTH);

    state_t            state;
    state_t            state_nx;
    logic              inflight;
    logic [1:0]        occ;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [DATA_W-1:0] mem [SKID_DEPTH];

    logic              accept;
    logic              land;
    logic              last_guard;
    logic [2:0]        room_used;

    assign out_valid  = (occ != 2'd0) && (state != FLUSH);
    assign out_data   = mem[rd_ptr];
    assign busy       = (state != IDLE);
    assign accept     = out_valid && out_ready;
    // A word landing while flushing (or being flushed) is dropped.
    assign land       = inflight && (state != FLUSH) && !flush;
    assign last_guard = fifo_almost_empty && inflight;
    // Slots claimed after this cycle: stored + arriving - leaving.
    assign room_used  = {1'b0, occ} + {2'b00, inflight}
                      - {2'b00, accept};

    // Next-state, pop strobe and flush completion pulse.
    always_comb begin
        state_nx   = state;
        fifo_rd_en = 1'b0;
        flush_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable && !fifo_empty)
                    state_nx = RUN;
            end
            RUN: begin
                fifo_rd_en = !fifo_empty
                           && (room_used < SKID_LIM)
                           && !last_guard;
                if (!enable
                    || (fifo_empty && !inflight && occ == 2'd0))
                    state_nx = IDLE;
            end
            FLUSH: begin
                fifo_rd_en = !fifo_empty && !last_guard;
                if (fifo_empty && !inflight) begin
                    state_nx   = IDLE;
                    flush_done = !flush;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (flush)
            state_nx = FLUSH;
    end

    // State register and one-cycle read-latency tracker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            inflight <= 1'b0;
        end else begin
            state    <= state_nx;
            inflight <= fifo_rd_en;
        end
    end

    // Skid buffer: tail write on landing, head advance on handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            occ    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (land) begin
                mem[wr_ptr] <= fifo_data_out;
                wr_ptr      <= ~wr_ptr;
            end
            if (accept)
                rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, land} - {1'b0, accept};
        end
    end

`ifdef POP_STATS_EN
    // Pop counter wraps; stall counter saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_count   <= '0;
            stall_count <= '0;
        end else if (flush) begin
            pop_count   <= '0;
            stall_count <= '0;
        end else begin
            pop_count <= pop_count + 16'(fifo_rd_en);
            if (out_valid && !out_ready
                && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule
